// File: rtl/ws2812_frame_sequencer.sv
// rtl/ws2812_frame_sequencer.sv - sequences one WS2812 refresh frame into the ws2812_output serializer
// Fetches BYTE_COUNT bytes per frame through a one-byte hold register and rate-limits frame starts.
module ws2812_frame_sequencer #(
    parameter int BYTE_COUNT    = 33,
    parameter int COUNT_WIDTH   = 6,
    parameter int PERIOD_CYCLES = 240000,
    parameter int PERIOD_WIDTH  = 24
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enable,
    input  logic [7:0] src_data,
    input  logic       src_valid,
    output logic       src_ready,
    output logic       ws_trigger,
    output logic [7:0] ws_data,
    output logic       ws_more,
    input  logic       ws_data_request,
    output logic       busy,
    output logic       frame_start,
    output logic       frame_done,
    output logic       underrun
);

    typedef enum logic [1:0] {IDLE, PREFETCH, SEND, TAIL} state_t;

    localparam logic [COUNT_WIDTH-1:0]  BYTES_INIT    = COUNT_WIDTH'(BYTE_COUNT);
    localparam logic [PERIOD_WIDTH-1:0] PERIOD_RELOAD =
        (PERIOD_CYCLES == 0) ? '0 : PERIOD_WIDTH'(PERIOD_CYCLES - 1);

    state_t                  state;
    logic [7:0]              hold_data;
    logic                    hold_valid;
    logic [COUNT_WIDTH-1:0]  bytes_left;
    logic [COUNT_WIDTH-1:0]  fetch_left;
    logic [PERIOD_WIDTH-1:0] period_cnt;

    logic                   start;
    logic                   transfer;
    logic                   last_request;
    logic                   hold_valid_next;
    logic [COUNT_WIDTH-1:0] fetch_next;

    assign start           = (state == IDLE) && enable && (period_cnt == '0);
    assign transfer        = src_valid && src_ready;
    assign last_request    = ws_data_request && (bytes_left == COUNT_WIDTH'(1));
    assign hold_valid_next = transfer || (hold_valid && !ws_data_request);
    assign fetch_next      = fetch_left - COUNT_WIDTH'(transfer);

    assign busy    = (state != IDLE);
    assign ws_data = hold_valid ? hold_data : 8'h00;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            src_ready   <= 1'b0;
            ws_trigger  <= 1'b0;
            ws_more     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
            hold_data   <= 8'h00;
            hold_valid  <= 1'b0;
            bytes_left  <= '0;
            fetch_left  <= '0;
            period_cnt  <= '0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;

            // Period runs from frame start to frame start, independent of frame length.
            if (start) begin
                period_cnt <= PERIOD_RELOAD;
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - PERIOD_WIDTH'(1);
            end

            if (transfer) begin
                hold_data <= src_data;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PREFETCH;
                        frame_start <= 1'b1;
                        bytes_left  <= BYTES_INIT;
                        fetch_left  <= BYTES_INIT;
                        src_ready   <= 1'b1;
                    end
                end
                PREFETCH: begin
                    if (transfer) begin
                        state      <= SEND;
                        hold_valid <= 1'b1;
                        fetch_left <= fetch_next;
                        src_ready  <= 1'b0;
                        ws_trigger <= 1'b1;
                        ws_more    <= 1'b1;
                    end
                end
                SEND: begin
                    if (ws_data_request) begin
                        bytes_left <= bytes_left - COUNT_WIDTH'(1);
                        if (!hold_valid) begin
                            underrun <= 1'b1;
                        end
                    end
                    fetch_left <= fetch_next;
                    if (last_request) begin
                        state      <= TAIL;
                        hold_valid <= 1'b0;
                        src_ready  <= 1'b0;
                        ws_trigger <= 1'b0;
                        ws_more    <= 1'b0;
                    end else begin
                        hold_valid <= hold_valid_next;
                        src_ready  <= !hold_valid_next && (fetch_next != '0);
                    end
                end
                TAIL: begin
                    if (ws_data_request) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
